// File: rtl/arbitro_memoria.sv
// -----------------------------------------------------------------------------
// arbitro_memoria
// Two-port memory arbiter. Port 0 (control unit) and port 1 (loader) request
// single accesses; the winner's request is latched onto the memory side and
// held until the memory answers or the wait limit expires. Ties are resolved
// round-robin against the last port served.
//
// Ports
//   Reloj, Reiniciar          clock, synchronous active-low reset
//   Sol0/1, Esc0/1            request and write select per port
//   Dir0/1, DatoEsc0/1        address and write data per port
//   Listo0/1, DatoLee0/1      one-cycle completion pulse and read data per port
//   Error                     timeout flag, pulses with Listo
//   Concedido                 one-hot owner of the memory (00 when idle)
//   MemSol, MemEsc            memory request and write strobe
//   MemDir, MemDatoEsc        latched address and write data
//   MemDatoLee, MemListo      memory read data and completion
// -----------------------------------------------------------------------------
module arbitro_memoria #(
    parameter int ANCHO_DIR  = 16,
    parameter int ANCHO_DATO = 16,
    parameter int LIMITE     = 15
) (
    input  logic                  Reloj,
    input  logic                  Reiniciar,
    input  logic                  Sol0,
    input  logic                  Sol1,
    input  logic                  Esc0,
    input  logic                  Esc1,
    input  logic [ANCHO_DIR-1:0]  Dir0,
    input  logic [ANCHO_DIR-1:0]  Dir1,
    input  logic [ANCHO_DATO-1:0] DatoEsc0,
    input  logic [ANCHO_DATO-1:0] DatoEsc1,
    output logic                  Listo0,
    output logic                  Listo1,
    output logic [ANCHO_DATO-1:0] DatoLee0,
    output logic [ANCHO_DATO-1:0] DatoLee1,
    output logic                  Error,
    output logic [1:0]            Concedido,
    output logic                  MemSol,
    output logic                  MemEsc,
    output logic [ANCHO_DIR-1:0]  MemDir,
    output logic [ANCHO_DATO-1:0] MemDatoEsc,
    input  logic [ANCHO_DATO-1:0] MemDatoLee,
    input  logic                  MemListo
);

    typedef enum logic [1:0] {REPOSO, ACCESO, ENTREGA} estado_t;

    localparam logic [7:0] LIM8   = 8'(LIMITE);
    localparam logic [7:0] LIM_M1 = 8'(LIMITE - 1);

    estado_t    estado, estado_sig;
    logic       ganador;      // port that owns the current access
    logic       ultimo;       // port served last, loses the next tie
    logic [7:0] cuenta;       // wait cycles already spent in ACCESO
    logic       gana;         // port that would win in REPOSO this cycle
    logic       fin_espera;   // this ACCESO cycle is the last one allowed

    // Next-cycle values of the registered outputs
    logic                  mem_sol_d, mem_esc_d, listo0_d, listo1_d, error_d;
    logic [1:0]            conc_d;
    logic [ANCHO_DIR-1:0]  mem_dir_d;
    logic [ANCHO_DATO-1:0] mem_dato_d, lee0_d, lee1_d;

    // Port 1 wins when it is alone, or on a tie when port 0 was served last.
    assign gana = (Sol0 && Sol1) ? ~ultimo : Sol1;

    // The counter reaches LIMITE on the edge that ends the LIMITE-th wait
    // cycle, so the timeout is taken one count early to keep MemSol high for
    // exactly LIMITE cycles.
    assign fin_espera = (cuenta >= LIM_M1);

    // ---------------------------------------------------------------- state
    always_ff @(posedge Reloj) begin
        if (!Reiniciar) begin
            estado  <= REPOSO;
            cuenta  <= '0;
            ultimo  <= 1'b1;
            ganador <= 1'b0;
        end else begin
            estado <= estado_sig;
            case (estado)
                REPOSO: begin
                    cuenta <= '0;
                    if (Sol0 || Sol1) ganador <= gana;
                end
                ACCESO:  cuenta <= (cuenta >= LIM8) ? LIM8 : cuenta + 8'd1;
                ENTREGA: begin
                    cuenta <= '0;
                    ultimo <= ganador;
                end
                default: cuenta <= '0;
            endcase
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO:  if (Sol0 || Sol1) estado_sig = ACCESO;
            ACCESO:  if (MemListo || fin_espera) estado_sig = ENTREGA;
            ENTREGA: estado_sig = REPOSO;
            default: estado_sig = REPOSO;
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        mem_sol_d  = MemSol;
        mem_esc_d  = MemEsc;
        mem_dir_d  = MemDir;
        mem_dato_d = MemDatoEsc;
        conc_d     = Concedido;
        lee0_d     = DatoLee0;
        lee1_d     = DatoLee1;
        listo0_d   = 1'b0;
        listo1_d   = 1'b0;
        error_d    = 1'b0;
        case (estado)
            REPOSO: begin
                mem_sol_d = 1'b0;
                conc_d    = 2'b00;
                if (Sol0 || Sol1) begin
                    mem_sol_d  = 1'b1;
                    conc_d     = gana ? 2'b10 : 2'b01;
                    mem_esc_d  = gana ? Esc1 : Esc0;
                    mem_dir_d  = gana ? Dir1 : Dir0;
                    mem_dato_d = gana ? DatoEsc1 : DatoEsc0;
                end
            end
            ACCESO: begin
                if (estado_sig == ENTREGA) begin
                    mem_sol_d = 1'b0;
                    mem_esc_d = 1'b0;
                    conc_d    = 2'b00;
                    // A real answer beats a timeout landing in the same cycle.
                    error_d   = ~MemListo;
                    if (ganador) listo1_d = 1'b1;
                    else         listo0_d = 1'b1;
                    if (!MemEsc) begin
                        if (ganador) lee1_d = MemListo ? MemDatoLee : '1;
                        else         lee0_d = MemListo ? MemDatoLee : '1;
                    end
                end
            end
            ENTREGA: begin
                mem_sol_d = 1'b0;
                conc_d    = 2'b00;
            end
            default: begin
                mem_sol_d = 1'b0;
                conc_d    = 2'b00;
            end
        endcase
    end

    always_ff @(posedge Reloj) begin
        if (!Reiniciar) begin
            MemSol     <= 1'b0;
            MemEsc     <= 1'b0;
            MemDir     <= '0;
            MemDatoEsc <= '0;
            Concedido  <= 2'b00;
            DatoLee0   <= '0;
            DatoLee1   <= '0;
            Listo0     <= 1'b0;
            Listo1     <= 1'b0;
            Error      <= 1'b0;
        end else begin
            MemSol     <= mem_sol_d;
            MemEsc     <= mem_esc_d;
            MemDir     <= mem_dir_d;
            MemDatoEsc <= mem_dato_d;
            Concedido  <= conc_d;
            DatoLee0   <= lee0_d;
            DatoLee1   <= lee1_d;
            Listo0     <= listo0_d;
            Listo1     <= listo1_d;
            Error      <= error_d;
        end
    end

endmodule

// File: tb/tb_arbitro_memoria.sv
// -----------------------------------------------------------------------------
// tb_arbitro_memoria
// Directed scenarios followed by random transactions. The bench plays both
// requesters and the memory; expected grants, latencies, data and error flags
// come from a transaction-level model (round-robin pointer, per-port read
// registers, timeout = memory slower than LIM cycles).
// -----------------------------------------------------------------------------
module tb_arbitro_memoria;

    localparam int AD  = 16;
    localparam int DW  = 16;
    localparam int LIM = 5;

    logic          Reloj = 1'b0;
    logic          Reiniciar;
    logic          Sol0, Sol1, Esc0, Esc1;
    logic [AD-1:0] Dir0, Dir1;
    logic [DW-1:0] DatoEsc0, DatoEsc1;
    logic          Listo0, Listo1;
    logic [DW-1:0] DatoLee0, DatoLee1;
    logic          Error;
    logic [1:0]    Concedido;
    logic          MemSol, MemEsc;
    logic [AD-1:0] MemDir;
    logic [DW-1:0] MemDatoEsc;
    logic [DW-1:0] MemDatoLee;
    logic          MemListo;

    arbitro_memoria #(.ANCHO_DIR(AD), .ANCHO_DATO(DW), .LIMITE(LIM)) dut (
        .Reloj(Reloj), .Reiniciar(Reiniciar),
        .Sol0(Sol0), .Sol1(Sol1), .Esc0(Esc0), .Esc1(Esc1),
        .Dir0(Dir0), .Dir1(Dir1), .DatoEsc0(DatoEsc0), .DatoEsc1(DatoEsc1),
        .Listo0(Listo0), .Listo1(Listo1), .DatoLee0(DatoLee0), .DatoLee1(DatoLee1),
        .Error(Error), .Concedido(Concedido),
        .MemSol(MemSol), .MemEsc(MemEsc), .MemDir(MemDir), .MemDatoEsc(MemDatoEsc),
        .MemDatoLee(MemDatoLee), .MemListo(MemListo)
    );

    always #5 Reloj = ~Reloj;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int            ultimo_m;
    logic [DW-1:0] lee_m [2];

    task automatic tick();
        @(posedge Reloj);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_todo_cero(input string tag);
        chk({tag, " MemSol"}, MemSol, 0);
        chk({tag, " MemEsc"}, MemEsc, 0);
        chk({tag, " MemDir"}, MemDir, 0);
        chk({tag, " MemDatoEsc"}, MemDatoEsc, 0);
        chk({tag, " Listo0"}, Listo0, 0);
        chk({tag, " Listo1"}, Listo1, 0);
        chk({tag, " DatoLee0"}, DatoLee0, 0);
        chk({tag, " DatoLee1"}, DatoLee1, 0);
        chk({tag, " Error"}, Error, 0);
        chk({tag, " Concedido"}, Concedido, 0);
    endtask

    // Idle cycles with no request; a stray MemListo must be ignored.
    task automatic reposo(input int n, input logic ml);
        for (int i = 0; i < n; i++) begin
            Sol0 = 1'b0; Sol1 = 1'b0;
            MemListo = ml; MemDatoLee = 16'(($urandom));
            tick();
            chk("idle MemSol", MemSol, 0);
            chk("idle Listo", {Listo1, Listo0}, 0);
            chk("idle Error", Error, 0);
            chk("idle Concedido", Concedido, 0);
        end
        MemListo = 1'b0;
    endtask

    // One access from the requesters' point of view. Called in a REPOSO cycle;
    // returns in the REPOSO cycle after the access. demora = cycle of MemSol in
    // which the memory answers; beyond LIM the memory never answers.
    task automatic transaccion(input logic s0, input logic s1,
                               input logic e0, input logic e1,
                               input logic [AD-1:0] d0, input logic [AD-1:0] d1,
                               input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                               input int demora, input logic [DW-1:0] rdata,
                               input bit soltar, input bit revolver, input bit mantener);
        int            w, n_esp;
        logic          esc_w, err;
        logic [AD-1:0] dir_w;
        logic [DW-1:0] dato_w;
        w      = (s0 && s1) ? (1 - ultimo_m) : (s1 ? 1 : 0);
        esc_w  = w ? e1 : e0;
        dir_w  = w ? d1 : d0;
        dato_w = w ? w1 : w0;
        err    = (demora > LIM);
        n_esp  = err ? LIM : demora;

        Sol0 = s0; Sol1 = s1; Esc0 = e0; Esc1 = e1;
        Dir0 = d0; Dir1 = d1; DatoEsc0 = w0; DatoEsc1 = w1;
        MemListo = 1'b0;
        tick();
        for (int c = 1; c <= n_esp; c++) begin
            chk("acc MemSol", MemSol, 1);
            chk("acc Concedido", Concedido, w ? 2'b10 : 2'b01);
            chk("acc MemEsc", MemEsc, esc_w);
            chk("acc MemDir", MemDir, dir_w);
            chk("acc MemDatoEsc", MemDatoEsc, dato_w);
            chk("acc Listo", {Listo1, Listo0}, 0);
            if (soltar && c == 1) begin
                if (w == 1) Sol1 = 1'b0; else Sol0 = 1'b0;
            end
            if (revolver) begin
                Esc0 = 1'($urandom); Esc1 = 1'($urandom);
                Dir0 = 16'($urandom); Dir1 = 16'($urandom);
                DatoEsc0 = 16'($urandom); DatoEsc1 = 16'($urandom);
            end
            MemListo   = (c == demora);
            MemDatoLee = (c == demora) ? rdata : 16'($urandom);
            tick();
        end
        MemListo = 1'b0;
        if (!esc_w) lee_m[w] = err ? 16'hFFFF : rdata;
        chk("done Listo0", Listo0, (w == 0));
        chk("done Listo1", Listo1, (w == 1));
        chk("done Error", Error, err);
        chk("done MemSol", MemSol, 0);
        chk("done DatoLee0", DatoLee0, lee_m[0]);
        chk("done DatoLee1", DatoLee1, lee_m[1]);
        ultimo_m = w;
        if (!mantener) begin Sol0 = 1'b0; Sol1 = 1'b0; end
        tick();
        chk("after Listo", {Listo1, Listo0}, 0);
        chk("after Error", Error, 0);
        chk("after Concedido", Concedido, 0);
        chk("after MemSol", MemSol, 0);
        chk("after DatoLee0", DatoLee0, lee_m[0]);
        chk("after DatoLee1", DatoLee1, lee_m[1]);
    endtask

    initial begin
        Reiniciar = 1'b0;
        Sol0 = 0; Sol1 = 0; Esc0 = 0; Esc1 = 0;
        Dir0 = '0; Dir1 = '0; DatoEsc0 = '0; DatoEsc1 = '0;
        MemDatoLee = '0; MemListo = 1'b0;
        ultimo_m = 1; lee_m[0] = '0; lee_m[1] = '0;

        // Reset state
        tick(); tick();
        chk_todo_cero("reset");
        Reiniciar = 1'b1;
        reposo(2, 1'b1);

        // Port 0 read, memory answers in the third cycle
        transaccion(1, 0, 0, 0, 16'h0010, 16'h0, 16'h0, 16'h0, 3, 16'hBEEF, 0, 0, 0);

        // Both ports held for three accesses: 0, 1, 0 (port 0 was served last,
        // so reset the pointer first to get the order from reset)
        Reiniciar = 1'b0; tick(); Reiniciar = 1'b1;
        ultimo_m = 1; lee_m[0] = '0; lee_m[1] = '0;
        chk_todo_cero("reset2");
        transaccion(1, 1, 0, 0, 16'h0100, 16'h0101, 16'h0, 16'h0, 1, 16'h1111, 0, 0, 1);
        chk("rr first", ultimo_m, 0);
        transaccion(1, 1, 0, 0, 16'h0100, 16'h0101, 16'h0, 16'h0, 2, 16'h2222, 0, 0, 1);
        chk("rr second", ultimo_m, 1);
        transaccion(1, 1, 0, 0, 16'h0100, 16'h0101, 16'h0, 16'h0, 1, 16'h3333, 0, 0, 0);

        // Port 1 write, memory silent: timeout after LIM cycles
        transaccion(0, 1, 0, 1, 16'h0, 16'h0200, 16'h0, 16'h1234, LIM + 3, 16'h0, 0, 0, 0);
        // Port 0 read timeout loads all-ones
        transaccion(1, 0, 0, 0, 16'h0042, 16'h0, 16'h0, 16'h0, LIM + 1, 16'h0, 0, 0, 0);
        // Memory answers on the very last allowed cycle: no error
        transaccion(0, 1, 1, 0, 16'h0, 16'h0300, 16'h0, 16'h0, LIM, 16'h5A5A, 0, 0, 0);

        // Sol0 dropped during the access
        transaccion(1, 0, 0, 0, 16'h0077, 16'h0, 16'h0, 16'h0, 2, 16'hCAFE, 1, 0, 0);
        reposo(1, 1'b0);

        // Reset during ACCESO; pointer left at port 0 before the reset
        chk("pre-reset pointer", ultimo_m, 0);
        Sol0 = 1'b1; Esc0 = 1'b0; Dir0 = 16'h0999; MemListo = 1'b0;
        tick();
        chk("rst acc MemSol", MemSol, 1);
        tick();
        Reiniciar = 1'b0;
        tick();
        chk_todo_cero("rst in ACCESO");
        Reiniciar = 1'b1; Sol0 = 1'b0; MemListo = 1'b1; MemDatoLee = 16'hDEAD;
        tick();
        chk("rst no Listo", {Listo1, Listo0}, 0);
        chk("rst no Error", Error, 0);
        chk("rst MemSol", MemSol, 0);
        MemListo = 1'b0;
        ultimo_m = 1; lee_m[0] = '0; lee_m[1] = '0;
        transaccion(1, 1, 0, 0, 16'h0001, 16'h0002, 16'h0, 16'h0, 2, 16'h4444, 0, 0, 0);
        chk("rst tie winner", ultimo_m, 0);

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            logic [1:0]    sel;
            logic          e0, e1;
            logic [AD-1:0] d0, d1;
            logic [DW-1:0] w0, w1, rd;
            int            dem;
            bit            so, rv, mt;
            sel = 2'($urandom_range(1, 3));
            e0 = 1'($urandom); e1 = 1'($urandom);
            d0 = 16'($urandom); d1 = 16'($urandom);
            w0 = 16'($urandom); w1 = 16'($urandom); rd = 16'($urandom);
            dem = $urandom_range(1, LIM + 2);
            so = ($urandom_range(0, 3) == 0);
            rv = 1'($urandom);
            mt = ($urandom_range(0, 3) == 0);
            transaccion(sel[0], sel[1], e0, e1, d0, d1, w0, w1, dem, rd, so, rv, mt);
            if (!mt) reposo($urandom_range(0, 2), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
